cci_mpf_csr_event_counter_bank: RTL
===================================

// Module: cci_mpf_csr_event_counter_bank
//
// PURPOSE
//   Parametrised bank of event counters. Shim event wires (VTP hit/miss, PT walk
//   busy, VC map changes, WRO conflicts, ...) are summed into per-event counters.
//   The bank sits behind the MPF CSR manager and serves pipelined MMIO-style
//   reads, per-counter and global clears, and an atomic snapshot.
//   It replaces the hard-wired per-shim counters with one generic, width-scalable block.
//
// PARAMETERS
//   N_EVENTS      8   number of event channels (1..64)
//   INC_WIDTH     1   bits per event increment (1 = pulse; >1 = count per cycle)
//   CNT_WIDTH     48  counter width (INC_WIDTH < CNT_WIDTH <= 64)
//   SATURATE      0   1: counters stick at all-ones; 0: counters wrap modulo 2^CNT_WIDTH
//   SNAPSHOT_EN   1   1: reads return the shadow bank; 0: reads return live counters
//
// PORTS
//   clk           in   1                    clock
//   reset         in   1                    synchronous, active-high reset
//   evt_inc       in   N_EVENTS*INC_WIDTH   per-event increment, channel i at [i*INC_WIDTH +: INC_WIDTH]
//   rd_req_valid  in   1                    read request strobe
//   rd_req_idx    in   $clog2(N_EVENTS+1)   counter index; index N_EVENTS = overflow status word
//   rd_rsp_valid  out  1                    read response valid
//   rd_rsp_data   out  64                   zero-extended counter or status value
//   clr_valid     in   1                    clear the counter at clr_idx
//   clr_idx       in   $clog2(N_EVENTS)     counter to clear
//   clr_all       in   1                    clear all counters and overflow flags
//   snap          in   1                    copy all live counters to the shadow bank
//
// BEHAVIOUR
//   - Reset: counters, shadow bank and overflow flags = 0; rd_rsp_valid = 0; rd_rsp_data = 0.
//     Reset drops in-flight reads; no response is issued for them.
//   - Counting: each cycle, cnt[i] <= cnt[i] + evt_inc[i].
//     Increment arithmetic is CNT_WIDTH+1 bits wide; the carry bit sets sticky ovf[i].
//     SATURATE=1: on carry, cnt[i] <= all-ones. SATURATE=0: cnt[i] keeps the low CNT_WIDTH bits.
//   - Clear: clr_valid clears cnt[i] and ovf[i] for i == clr_idx.
//     clr_all clears every counter and flag; it does not affect the shadow bank.
//     If a clear and an increment hit the same counter in one cycle, the clear applies first,
//     so cnt[i] <= evt_inc[i] and ovf[i] <= 0.
//     clr_idx >= N_EVENTS is ignored.
//   - Snapshot (SNAPSHOT_EN=1): snap copies the pre-update live value of every counter
//     into the shadow bank in the same cycle. The copy excludes the increments of that cycle.
//     If snap and a clear occur together, the shadow gets the pre-clear value.
//     SNAPSHOT_EN=0: snap is ignored and the shadow bank is not built.
//   - Read pipeline: fully pipelined, one request per cycle accepted, no backpressure.
//     rd_rsp_valid asserts exactly 2 cycles after rd_req_valid.
//     Stage 1 registers the index and decodes it. Stage 2 registers the mux output.
//     Read data is sampled at stage 1, from the shadow or live bank.
//     Responses return in request order.
//     idx == N_EVENTS returns the ovf[] vector in bits [N_EVENTS-1:0], zero above.
//     idx > N_EVENTS returns 0 with rd_rsp_valid = 1.
//   - Counter values are zero-extended to 64 bits. rd_rsp_data = 0 whenever rd_rsp_valid = 0.
//   - No internal FSM beyond the 2-stage read pipe; all events are accepted every cycle.
//
// TESTING
//   1. Reset, pulse evt_inc[2]=1 for 10 cycles, snap, read idx 2
//      -> rd_rsp_valid 2 cycles after the request, data = 10.
//   2. CNT_WIDTH=8, SATURATE=0: drive 260 pulses on ch0, snap, read 0 and read 8 (status)
//      -> data 4; status bit0 = 1.
//      Repeat with SATURATE=1 -> data 255, status bit0 = 1.
//   3. INC_WIDTH=4: evt_inc ch1 = 15 on the same cycle as clr_valid, clr_idx=1, then snap
//      -> read 1 returns 15.
//   4. ch3 at 100. Snap, then pulse 5 more and clr_all, then read 3 with SNAPSHOT_EN=1
//      -> 100 (shadow intact). With SNAPSHOT_EN=0 -> 0.
//   5. Back-to-back reads idx 0,1,2,9 (N_EVENTS=8) on consecutive cycles
//      -> 4 consecutive responses in order; idx 9 returns 0 with valid = 1.
//   6. Assert reset for 1 cycle one cycle after a read request
//      -> no rd_rsp_valid for that request; all counters read 0 afterwards.

Source files
------------

// File: rtl/cci_mpf_csr_event_counter_bank.sv
// cci_mpf_csr_event_counter_bank
//
// Generic bank of event counters for the MPF shims. Every channel adds its
// per-cycle increment into a live counter and records a sticky overflow flag.
// An optional shadow bank holds an atomic snapshot of all live counters.
// Reads go through a fixed two-stage pipeline, with one request accepted per
// cycle. Reading index N_EVENTS returns the overflow vector. Reading any
// higher index returns zero.
module cci_mpf_csr_event_counter_bank #(
    parameter int N_EVENTS    = 8,
    parameter int INC_WIDTH   = 1,
    parameter int CNT_WIDTH   = 48,
    parameter int SATURATE    = 0,
    parameter int SNAPSHOT_EN = 1,
    localparam int RD_W  = $clog2(N_EVENTS + 1),
    localparam int CLR_W = (N_EVENTS > 1) ? $clog2(N_EVENTS) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_EVENTS*INC_WIDTH-1:0] evt_inc,
    input  logic                          rd_req_valid,
    input  logic [RD_W-1:0]               rd_req_idx,
    output logic                          rd_rsp_valid,
    output logic [63:0]                   rd_rsp_data,
    input  logic                          clr_valid,
    input  logic [CLR_W-1:0]              clr_idx,
    input  logic                          clr_all,
    input  logic                          snap
);

    localparam int SUM_W = CNT_WIDTH + 1;

    // Live counters, overflow flags, and the bank that reads observe.
    logic [CNT_WIDTH-1:0] cnt_live [N_EVENTS];
    logic [CNT_WIDTH-1:0] rd_bank  [N_EVENTS];
    logic [N_EVENTS-1:0]  ovf;

    genvar i;
    generate
        for (i = 0; i < N_EVENTS; i++) begin : g_ch
            logic                 clr_hit;
            logic [CNT_WIDTH-1:0] base;
            logic [SUM_W-1:0]     sum;
            logic [CNT_WIDTH-1:0] cnt_q;
            logic                 ovf_q;

            // A clear applies before the increment of the same cycle. The sum
            // is one bit wider than the counter so that its top bit is the
            // carry out of the add.
            assign clr_hit = clr_all | (clr_valid & (clr_idx == CLR_W'(i)));
            assign base    = clr_hit ? '0 : cnt_q;
            assign sum     = {1'b0, base} + SUM_W'(evt_inc[i*INC_WIDTH +: INC_WIDTH]);

            // Counter update. A carry sets the sticky overflow flag. The
            // counter then either saturates at all-ones or keeps the wrapped
            // low bits.
            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_q <= '0;
                    ovf_q <= 1'b0;
                end else if (sum[CNT_WIDTH]) begin
                    cnt_q <= (SATURATE != 0) ? '1 : sum[CNT_WIDTH-1:0];
                    ovf_q <= 1'b1;
                end else begin
                    cnt_q <= sum[CNT_WIDTH-1:0];
                    ovf_q <= clr_hit ? 1'b0 : ovf_q;
                end
            end

            assign cnt_live[i] = cnt_q;
            assign ovf[i]      = ovf_q;

            if (SNAPSHOT_EN != 0) begin : g_shadow
                logic [CNT_WIDTH-1:0] shadow_q;

                // Snapshot captures the pre-update live value. This value
                // excludes the increments of this cycle and is taken before
                // any clear. Clears never touch the shadow.
                always_ff @(posedge clk) begin
                    if (reset) begin
                        shadow_q <= '0;
                    end else if (snap) begin
                        shadow_q <= cnt_q;
                    end
                end

                assign rd_bank[i] = shadow_q;
            end else begin : g_live
                assign rd_bank[i] = cnt_q;
            end
        end

        if (SNAPSHOT_EN == 0) begin : g_no_snap
            logic unused_snap;
            assign unused_snap = snap;
        end
    endgenerate

    // Read pipeline stage 1 and stage 2 registers.
    logic            s1_valid;
    logic [RD_W-1:0] s1_idx;
    logic            s1_is_cnt;
    logic            s1_is_ovf;
    logic [63:0]     mux_data;

    // Stage 1 registers the request and pre-decodes which source it selects.
    // An out-of-range index selects neither source and therefore reads zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_idx    <= '0;
            s1_is_cnt <= 1'b0;
            s1_is_ovf <= 1'b0;
        end else begin
            s1_valid  <= rd_req_valid;
            s1_idx    <= rd_req_idx;
            s1_is_cnt <= rd_req_valid && (rd_req_idx < RD_W'(N_EVENTS));
            s1_is_ovf <= rd_req_valid && (rd_req_idx == RD_W'(N_EVENTS));
        end
    end

    // Select the zero-extended counter or status word for the stage 1 request.
    // The result is zero when no request is in stage 1.
    always_comb begin
        mux_data = '0;
        if (s1_is_ovf) begin
            mux_data = 64'(ovf);
        end else if (s1_is_cnt) begin
            for (int k = 0; k < N_EVENTS; k++) begin
                if (s1_idx == RD_W'(k)) begin
                    mux_data = 64'(rd_bank[k]);
                end
            end
        end
    end

    // Stage 2 registers the response. Reset drops any read in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_rsp_valid <= 1'b0;
            rd_rsp_data  <= '0;
        end else begin
            rd_rsp_valid <= s1_valid;
            rd_rsp_data  <= mux_data;
        end
    end

endmodule
